axicb_prio_arbiter: RTL and testbench

AXICB_PRIO_ARBITER -- requirements
Module: axicb_prio_arbiter

---
 rtl/axicb_pkg.sv | 18 +
 rtl/axicb_rr_pick.sv | 49 ++++
 rtl/axicb_prio_arbiter.sv | 163 ++++++++++++++++
 tb/tb_axicb_prio_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/axicb_pkg.sv
// ---------------------------------------------------------------------------
// axicb_pkg
// Shared definitions for the AXI crossbar priority arbiter:
//   arb_state_e   - arbiter FSM state (IDLE, GRANTED)
//   AXICB_PRIO_W  - width of one requester priority field (3 = highest)
//   AXICB_MAX_REQ - largest supported requester count
// ---------------------------------------------------------------------------
package axicb_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  localparam int AXICB_PRIO_W  = 2;
  localparam int AXICB_MAX_REQ = 8;

endpackage : axicb_pkg

// File: rtl/axicb_rr_pick.sv
// ---------------------------------------------------------------------------
// axicb_rr_pick
// Combinational round-robin find-first-set: returns the first set bit of
// req at or after rr_ptr, wrapping from N-1 back to 0.
// Ports:
//   req     [N-1:0]     in  candidate requesters (already priority-masked)
//   rr_ptr  [IDX_W-1:0] in  round-robin start position (< N)
//   win     [N-1:0]     out one-hot winner (0 when req is 0)
//   win_idx [IDX_W-1:0] out winner index (0 when req is 0)
// ---------------------------------------------------------------------------
module axicb_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] win_idx
);

  logic found_s;

  // Two ascending scans: first the indices at/after rr_ptr, then the wrapped
  // indices below it; the first hit is the round-robin winner.
  always_comb begin
    win     = {N{1'b0}};
    win_idx = {IDX_W{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found_s && req[i] && (IDX_W'(i) >= rr_ptr)) begin
        win[i]  = 1'b1;
        win_idx = IDX_W'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found_s && req[i] && (IDX_W'(i) < rr_ptr)) begin
        win[i]  = 1'b1;
        win_idx = IDX_W'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule : axicb_rr_pick

// File: rtl/axicb_prio_arbiter.sv
// ---------------------------------------------------------------------------
// axicb_prio_arbiter
// Fixed-priority + round-robin arbiter. Among active requesters only those
// at the highest active priority level compete; ties are broken round-robin
// from rr_ptr. A grant is held until en (handshake done) or until the
// granted requester withdraws; new requests never pre-empt a grant.
//
// Optional feature (macro AXICB_ARB_TIMEOUT_EN): a stall counter releases a
// grant after TIMEOUT_CYCLES granted cycles without en, pulses tmo, advances
// rr_ptr and masks the stalled requester for the following arbitration.
//
// Ports:
//   aclk      in   clock, rising edge
//   srst      in   synchronous active-high reset
//   req       in   [REQ_NB] request levels
//   en        in   handshake-complete pulse for the granted requester
//   grant     out  [REQ_NB] one-hot registered grant
//   grant_vld out  high while a grant is held
//   grant_idx out  [$clog2(REQ_NB)] granted index, 0 when idle
//   tmo       out  one-cycle timeout pulse (0 without the feature)
// ---------------------------------------------------------------------------
module axicb_prio_arbiter
  import axicb_pkg::*;
#(
  parameter int                                REQ_NB         = 4,
  parameter logic [REQ_NB*AXICB_PRIO_W-1:0]    REQ_PRIO       = {(REQ_NB*AXICB_PRIO_W){1'b0}},
  parameter int                                TIMEOUT_CYCLES = 256
) (
  input  logic                       aclk,
  input  logic                       srst,
  input  logic [REQ_NB-1:0]          req,
  input  logic                       en,
  output logic [REQ_NB-1:0]          grant,
  output logic                       grant_vld,
  output logic [$clog2(REQ_NB)-1:0]  grant_idx,
  output logic                       tmo
);

  localparam int IDX_W = $clog2(REQ_NB);

  if (REQ_NB < 2 || REQ_NB > AXICB_MAX_REQ || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("axicb_prio_arbiter: parameter out of range");
  end

  arb_state_e              state_r;
  logic [IDX_W-1:0]        rr_ptr_r;
  logic [REQ_NB-1:0]       active_s;
  logic [AXICB_PRIO_W-1:0] top_prio_s;
  logic [REQ_NB-1:0]       cand_s;
  logic [REQ_NB-1:0]       pick_s;
  logic [IDX_W-1:0]        pick_idx_s;
  logic [IDX_W-1:0]        next_ptr_s;

`ifdef AXICB_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]       tmo_cnt_r;
  logic [REQ_NB-1:0] excl_r;

  // A requester that just timed out sits out one arbitration.
  assign active_s = req & ~excl_r;
`else
  assign active_s = req;
  assign tmo      = 1'b0;
`endif

  // Successor of the current grant, wrapping at REQ_NB-1.
  assign next_ptr_s = (grant_idx == IDX_W'(REQ_NB - 1)) ? {IDX_W{1'b0}} : grant_idx + 1'b1;

  // Find the highest active priority level and keep only requesters at it.
  always_comb begin
    top_prio_s = {AXICB_PRIO_W{1'b0}};
    cand_s     = {REQ_NB{1'b0}};
    for (int i = 0; i < REQ_NB; i++) begin
      if (active_s[i] && (REQ_PRIO[i*AXICB_PRIO_W +: AXICB_PRIO_W] > top_prio_s)) begin
        top_prio_s = REQ_PRIO[i*AXICB_PRIO_W +: AXICB_PRIO_W];
      end else begin
        top_prio_s = top_prio_s;
      end
    end
    for (int i = 0; i < REQ_NB; i++) begin
      cand_s[i] = active_s[i] && (REQ_PRIO[i*AXICB_PRIO_W +: AXICB_PRIO_W] == top_prio_s);
    end
  end

  axicb_rr_pick #(
    .N     (REQ_NB),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (cand_s),
    .rr_ptr  (rr_ptr_r),
    .win     (pick_s),
    .win_idx (pick_idx_s)
  );

  // Arbiter FSM with registered grant outputs; en beats withdrawal, and
  // both beat the stall timeout.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_r   <= IDLE;
      rr_ptr_r  <= {IDX_W{1'b0}};
      grant     <= {REQ_NB{1'b0}};
      grant_vld <= 1'b0;
      grant_idx <= {IDX_W{1'b0}};
`ifdef AXICB_ARB_TIMEOUT_EN
      tmo       <= 1'b0;
      tmo_cnt_r <= 16'd0;
      excl_r    <= {REQ_NB{1'b0}};
`endif
    end else begin
`ifdef AXICB_ARB_TIMEOUT_EN
      tmo <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
`ifdef AXICB_ARB_TIMEOUT_EN
          excl_r    <= {REQ_NB{1'b0}};
          tmo_cnt_r <= 16'd0;
`endif
          if (|cand_s) begin
            grant     <= pick_s;
            grant_vld <= 1'b1;
            grant_idx <= pick_idx_s;
            state_r   <= GRANTED;
          end
        end
        GRANTED: begin
          if (en) begin
            grant     <= {REQ_NB{1'b0}};
            grant_vld <= 1'b0;
            grant_idx <= {IDX_W{1'b0}};
            rr_ptr_r  <= next_ptr_s;
            state_r   <= IDLE;
          end else if (!req[grant_idx]) begin
            grant     <= {REQ_NB{1'b0}};
            grant_vld <= 1'b0;
            grant_idx <= {IDX_W{1'b0}};
            state_r   <= IDLE;
          end
`ifdef AXICB_ARB_TIMEOUT_EN
          else if (tmo_cnt_r == TMO_LAST) begin
            tmo       <= 1'b1;
            excl_r    <= grant;
            grant     <= {REQ_NB{1'b0}};
            grant_vld <= 1'b0;
            grant_idx <= {IDX_W{1'b0}};
            rr_ptr_r  <= next_ptr_s;
            state_r   <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
          end
`endif
        end
        default: begin
          grant     <= {REQ_NB{1'b0}};
          grant_vld <= 1'b0;
          grant_idx <= {IDX_W{1'b0}};
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule : axicb_prio_arbiter

// File: tb/tb_axicb_prio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axicb_prio_arbiter
// Directed bench with two arbiter instances sharing clock and reset:
//   u_eq  - equal priorities, TIMEOUT_CYCLES=4
//   u_pri - requester 2 at priority 3, others 0
// Inputs change and outputs are checked on the falling edge. Every falling
// edge also checks one-hot grant, grant_vld and grant_idx consistency.
// ---------------------------------------------------------------------------
module tb_axicb_prio_arbiter;

  logic       aclk = 1'b0;
  logic       srst;
  logic [3:0] req_a, req_b;
  logic       en_a, en_b;
  logic [3:0] grant_a, grant_b;
  logic       vld_a, vld_b;
  logic [1:0] idx_a, idx_b;
  logic       tmo_a, tmo_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  axicb_prio_arbiter #(
    .REQ_NB(4), .REQ_PRIO(8'b0000_0000), .TIMEOUT_CYCLES(4)
  ) u_eq (
    .aclk(aclk), .srst(srst), .req(req_a), .en(en_a),
    .grant(grant_a), .grant_vld(vld_a), .grant_idx(idx_a), .tmo(tmo_a)
  );

  axicb_prio_arbiter #(
    .REQ_NB(4), .REQ_PRIO(8'b0011_0000), .TIMEOUT_CYCLES(4)
  ) u_pri (
    .aclk(aclk), .srst(srst), .req(req_b), .en(en_b),
    .grant(grant_b), .grant_vld(vld_b), .grant_idx(idx_b), .tmo(tmo_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic inv(input string tag, input logic [3:0] g, input logic v, input logic [1:0] i);
    chk({tag, ".onehot"}, 32'($onehot0(g)), 32'd1);
    chk({tag, ".vld"},    32'(v),           32'(|g));
    chk({tag, ".idx"},    32'(i),           32'(enc(g)));
  endtask

  task automatic tick;
    @(negedge aclk);
    inv("inv_a", grant_a, vld_a, idx_a);
    inv("inv_b", grant_b, vld_b, idx_b);
  endtask

  task automatic exp_a(input string tag, input logic [3:0] g, input logic [1:0] i, input logic t);
    chk({tag, ".grant"}, 32'(grant_a), 32'(g));
    chk({tag, ".vld"},   32'(vld_a),   32'(|g));
    chk({tag, ".idx"},   32'(idx_a),   32'(i));
    chk({tag, ".tmo"},   32'(tmo_a),   32'(t));
  endtask

  task automatic exp_b(input string tag, input logic [3:0] g, input logic [1:0] i);
    chk({tag, ".grant"}, 32'(grant_b), 32'(g));
    chk({tag, ".vld"},   32'(vld_b),   32'(|g));
    chk({tag, ".idx"},   32'(idx_b),   32'(i));
    chk({tag, ".tmo"},   32'(tmo_b),   32'd0);
  endtask

  initial begin
    logic [1:0] seq_b [4];
    seq_b[0] = 2'd3; seq_b[1] = 2'd0; seq_b[2] = 2'd1; seq_b[3] = 2'd3;

    // Reset held with requests pending: outputs stay at zero.
    srst = 1'b1; req_a = 4'b1111; en_a = 1'b0; req_b = 4'b0000; en_b = 1'b0;
    tick; tick;
    exp_a("reset_a", 4'b0000, 2'd0, 1'b0);
    exp_b("reset_b", 4'b0000, 2'd0);

    // Equal priorities, en on every grant: 0,1,2,3,0 with an idle gap.
    srst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      exp_a("rr_grant", 4'(1 << (k % 4)), 2'(k % 4), 1'b0);
      en_a = 1'b1;
      tick;
      exp_a("rr_gap", 4'b0000, 2'd0, 1'b0);
      en_a = 1'b0;
    end

    // rr_ptr=1: grant 1, no pre-emption, then withdrawal keeps rr_ptr.
    req_a = 4'b0010;
    tick; exp_a("wd_grant1", 4'b0010, 2'd1, 1'b0);
    req_a = 4'b1111;
    tick; exp_a("no_preempt", 4'b0010, 2'd1, 1'b0);
    req_a = 4'b0101;
    tick; exp_a("wd_idle", 4'b0000, 2'd0, 1'b0);
    tick; exp_a("wd_next", 4'b0100, 2'd2, 1'b0);
    en_a = 1'b1;
    tick; exp_a("wd_release", 4'b0000, 2'd0, 1'b0);

    // en while idle must not move rr_ptr (still 3).
    req_a = 4'b0000;
    tick; exp_a("en_idle", 4'b0000, 2'd0, 1'b0);
    en_a = 1'b0;

    // Stall on grant 0 with req=0011, rr_ptr=3 wraps to 0.
    req_a = 4'b0011;
    tick; exp_a("stall_g1", 4'b0001, 2'd0, 1'b0);
    tick; tick;
    tick; exp_a("stall_g4", 4'b0001, 2'd0, 1'b0);
`ifdef AXICB_ARB_TIMEOUT_EN
    tick; exp_a("tmo_pulse", 4'b0000, 2'd0, 1'b1);
    tick; exp_a("tmo_next", 4'b0010, 2'd1, 1'b0);
    en_a = 1'b1;
    tick; exp_a("tmo_rel", 4'b0000, 2'd0, 1'b0);
    en_a = 1'b0;
    // rr_ptr=2: grant 0 again, en in the expiry cycle wins.
    tick; exp_a("enw_g1", 4'b0001, 2'd0, 1'b0);
    tick; tick; tick;
    en_a = 1'b1;
    tick; exp_a("en_wins", 4'b0000, 2'd0, 1'b0);
    en_a = 1'b0;
`else
    for (int k = 0; k < 8; k++) begin
      tick; exp_a("held", 4'b0001, 2'd0, 1'b0);
    end
    en_a = 1'b1;
    tick; exp_a("held_rel", 4'b0000, 2'd0, 1'b0);
    en_a = 1'b0;
`endif

    // rr_ptr=1: grant 1, then reset mid-grant together with en.
    req_a = 4'b1111;
    tick; exp_a("pre_rst", 4'b0010, 2'd1, 1'b0);
    srst = 1'b1; en_a = 1'b1;
    tick; exp_a("rst_mid", 4'b0000, 2'd0, 1'b0);
    srst = 1'b0; en_a = 1'b0;
    tick; exp_a("post_rst", 4'b0001, 2'd0, 1'b0);
    en_a = 1'b1;
    tick; exp_a("post_rel", 4'b0000, 2'd0, 1'b0);
    en_a = 1'b0; req_a = 4'b0000;

    // Requester 2 at top priority wins until it drops, then 3,0,1,3.
    req_b = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick; exp_b("prio_hi", 4'b0100, 2'd2);
      en_b = 1'b1;
      if (k == 2) req_b = 4'b1011;
      tick; exp_b("prio_gap", 4'b0000, 2'd0);
      en_b = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      tick; exp_b("prio_rr", 4'(1 << seq_b[k]), seq_b[k]);
      en_b = 1'b1;
      tick; exp_b("prio_rr_gap", 4'b0000, 2'd0);
      en_b = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_axicb_prio_arbiter
